// File: rtl/lsu_pkg.sv
// Shared constants for the load/store sequencer: opcodes, FSM states and
// instruction field positions.
package lsu_pkg;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    REQ  = 2'd2,
    FIN  = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [5:0] opc);
    return (opc == OP_LW) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_wait_timer.sv
// Memory wait counter: cleared outside the request phase, counts cycles
// without mem_ready.
module lsu_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // Flags the wait cycle whose increment brings the count to TIMEOUT, so the
  // request stays up for exactly TIMEOUT cycles.
  assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_access_ctrl.sv
// Multi-cycle LW/SW sequencer: effective address, memory req/ready handshake
// and load write-back.
//   state | meaning
//   IDLE  | waiting for start, operands latched on acceptance
//   ADDR  | effective address computed, opcode/alignment checked
//   REQ   | mem_req held until mem_ready or timeout
//   FIN   | one-cycle done, fault and write-back strobe
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] Read_data1,
  input  logic [DATA_W-1:0] Read_data2,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  lsu_state_e        state, state_d;
  logic [5:0]        opcode_q;
  logic [4:0]        rt_q;
  logic [15:0]       imm_q;
  logic [DATA_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] eff_addr;
  logic              is_lw;
  logic              expired;
  logic              unused_rs;

  assign unused_rs = ^instruction[RS_HI:RS_LO];

  assign eff_addr = base_q + {{(DATA_W-16){imm_q[15]}}, imm_q};
  assign is_lw    = (opcode_q == OP_LW);

  lsu_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != REQ),
    .en      ((state == REQ) && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d = state;
    fault_d = 1'b0;
    case (state)
      IDLE: if (start) state_d = ADDR;
      ADDR: begin
        if (!is_mem_op(opcode_q) || (eff_addr[1:0] != 2'b00)) begin
          state_d = FIN;
          fault_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = FIN;
        end else if (expired) begin
          state_d = FIN;
          fault_d = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fault_q  <= 1'b0;
      opcode_q <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state   <= state_d;
      fault_q <= fault_d;
      if (state == IDLE && start) begin
        opcode_q <= instruction[OPC_HI:OPC_LO];
        rt_q     <= instruction[RT_HI:RT_LO];
        imm_q    <= instruction[IMM_HI:IMM_LO];
        base_q   <= Read_data1;
        wdata_q  <= Read_data2;
      end
      if (state == ADDR) addr_q <= eff_addr;
      if (state == REQ && mem_ready && is_lw) rdata_q <= mem_rdata;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign fault     = fault_q;
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && (opcode_q == OP_SW);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rf_we     = done && is_lw && !fault_q && (rt_q != 5'd0);
  assign rf_waddr  = rt_q;
  assign rf_wdata  = rdata_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: directed vector table, hand sequences for
// start pulsing and mid-access reset, and randomized ops against a model.
module tb_lsu_access_ctrl;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              reset;
  logic              start;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] Read_data1, Read_data2;
  logic              busy, done, fault;
  logic              mem_req, mem_we;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  lsu_access_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
    .Read_data1(Read_data1), .Read_data2(Read_data2),
    .busy(busy), .done(done), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    int          delay;      // wait cycles before mem_ready, -1 = never
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    int          exp_lat;    // cycles from start to done
    int          exp_reqs;   // cycles with mem_req high
    bit          exp_fault;
    bit          exp_rfwe;
  } vec_t;

  vec_t vecs[10];

  // Behavioural reference: whole-transaction outcome from the instruction rules.
  function automatic void model(input logic [31:0] instr, input logic [31:0] rs,
                                input int delay, output logic [31:0] addr,
                                output int lat, output int reqs,
                                output bit flt, output bit rfwe);
    logic [5:0] op;
    bit lw, sw;
    int simm;
    op   = instr[31:26];
    lw   = (op == 6'h23);
    sw   = (op == 6'h2B);
    simm = int'($signed(instr[15:0]));
    addr = rs + 32'(simm);
    if ((!lw && !sw) || addr[1:0] != 2'b00) begin
      lat = 2; reqs = 0; flt = 1'b1; rfwe = 1'b0;
    end else if (delay >= 0 && delay + 1 <= TIMEOUT) begin
      reqs = delay + 1; lat = 2 + reqs; flt = 1'b0;
      rfwe = lw && (instr[20:16] != 5'd0);
    end else begin
      reqs = TIMEOUT; lat = 2 + TIMEOUT; flt = 1'b1; rfwe = 1'b0;
    end
  endfunction

  task automatic run_op(input string name, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input int delay, input logic [31:0] rdata,
                        input bit hold, input logic [31:0] exp_addr, input int exp_lat,
                        input int exp_reqs, input bit exp_fault, input bit exp_rfwe);
    int reqs;
    bit seen;
    bit is_sw;
    reqs  = 0;
    seen  = 1'b0;
    is_sw = (instr[31:26] == 6'h2B);
    @(negedge clk);
    chk({name, ":idle_busy"}, 32'(busy), 32'd0);
    chk({name, ":idle_done"}, 32'(done), 32'd0);
    start       = 1'b1;
    instruction = instr;
    Read_data1  = rs;
    Read_data2  = rt;
    mem_ready   = 1'($urandom_range(0, 1));
    mem_rdata   = $urandom;
    @(posedge clk);
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk);
      start       = hold;
      instruction = $urandom;
      Read_data1  = $urandom;
      Read_data2  = $urandom;
      chk({name, ":busy"}, 32'(busy), 32'd1);
      if (mem_req) begin
        reqs++;
        chk({name, ":mem_addr"}, mem_addr, exp_addr);
        chk({name, ":mem_we"}, 32'(mem_we), 32'(is_sw));
        if (is_sw) chk({name, ":mem_wdata"}, mem_wdata, rt);
        mem_ready = (delay >= 0 && reqs > delay);
        mem_rdata = mem_ready ? rdata : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (done) begin
        seen = 1'b1;
        chk({name, ":latency"}, 32'(c), 32'(exp_lat));
        chk({name, ":req_cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({name, ":fault"}, 32'(fault), 32'(exp_fault));
        chk({name, ":rf_we"}, 32'(rf_we), 32'(exp_rfwe));
        if (exp_rfwe) begin
          chk({name, ":rf_waddr"}, 32'(rf_waddr), 32'(instr[20:16]));
          chk({name, ":rf_wdata"}, rf_wdata, rdata);
        end
      end else begin
        chk({name, ":fault_idle"}, 32'(fault), 32'd0);
        chk({name, ":rf_we_idle"}, 32'(rf_we), 32'd0);
      end
    end
    chk({name, ":done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] instr, rs, rt, rdata, eaddr;
    int delay, lat, reqs, r;
    bit flt, rfwe;

    reset = 1'b0; start = 1'b0; instruction = '0; Read_data1 = '0; Read_data2 = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    vecs[0] = '{"sw_basic",     {6'h2B, 5'd1, 5'd2,  16'h0008}, 32'h0000_1000, 32'hDEAD_BEEF,  0, 32'h0,         32'h0000_1008,  3,  1, 1'b0, 1'b0};
    vecs[1] = '{"lw_wait3",     {6'h23, 5'd1, 5'd5,  16'hFFFC}, 32'h0000_2000, 32'h0,          3, 32'h1234_5678, 32'h0000_1FFC,  6,  4, 1'b0, 1'b1};
    vecs[2] = '{"sw_misalign",  {6'h2B, 5'd1, 5'd2,  16'h0000}, 32'h0000_1001, 32'h1111_2222,  0, 32'h0,         32'h0000_1001,  2,  0, 1'b1, 1'b0};
    vecs[3] = '{"bad_opcode",   {6'h00, 5'd1, 5'd2,  16'h0000}, 32'h0000_0100, 32'h0,          0, 32'h0,         32'h0000_0100,  2,  0, 1'b1, 1'b0};
    vecs[4] = '{"lw_timeout",   {6'h23, 5'd1, 5'd7,  16'h0004}, 32'h0000_3000, 32'h0,         -1, 32'h0,         32'h0000_3004, 17, 15, 1'b1, 1'b0};
    vecs[5] = '{"lw_rt0",       {6'h23, 5'd1, 5'd0,  16'h0000}, 32'h0000_4000, 32'h0,          0, 32'hCAFE_F00D, 32'h0000_4000,  3,  1, 1'b0, 1'b0};
    vecs[6] = '{"lw_last_wait", {6'h23, 5'd1, 5'd9,  16'h0020}, 32'h0000_5000, 32'h0,         14, 32'hA5A5_5A5A, 32'h0000_5020, 17, 15, 1'b0, 1'b1};
    vecs[7] = '{"lw_addr_wrap", {6'h23, 5'd2, 5'd31, 16'h0008}, 32'hFFFF_FFFC, 32'h0,          1, 32'h0BAD_BEEF, 32'h0000_0004,  4,  2, 1'b0, 1'b1};
    vecs[8] = '{"sw_imm_mis",   {6'h2B, 5'd1, 5'd2,  16'h0002}, 32'h0000_1000, 32'h0,          0, 32'h0,         32'h0000_1002,  2,  0, 1'b1, 1'b0};
    vecs[9] = '{"sw_neg_imm",   {6'h2B, 5'd3, 5'd4,  16'hFFF0}, 32'h0000_0000, 32'h7654_3210,  2, 32'h0,         32'hFFFF_FFF0,  5,  3, 1'b0, 1'b0};

    #2;
    chk("rst:busy",     32'(busy),     32'd0);
    chk("rst:done",     32'(done),     32'd0);
    chk("rst:fault",    32'(fault),    32'd0);
    chk("rst:mem_req",  32'(mem_req),  32'd0);
    chk("rst:mem_we",   32'(mem_we),   32'd0);
    chk("rst:mem_addr", mem_addr,      32'd0);
    chk("rst:rf_we",    32'(rf_we),    32'd0);
    chk("rst:rf_wdata", rf_wdata,      32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].delay, vecs[i].rdata,
             1'b0, vecs[i].exp_addr, vecs[i].exp_lat, vecs[i].exp_reqs, vecs[i].exp_fault,
             vecs[i].exp_rfwe);

    // start held high throughout: only the IDLE-cycle start may be taken.
    run_op("hold0", {6'h2B, 5'd1, 5'd2, 16'h0004}, 32'h0000_0600, 32'h0102_0304, 0, 32'h0, 1'b1,
           32'h0000_0604, 3, 1, 1'b0, 1'b0);
    run_op("hold1", {6'h23, 5'd1, 5'd6, 16'h0008}, 32'h0000_0700, 32'h0, 0, 32'h5555_AAAA, 1'b1,
           32'h0000_0708, 3, 1, 1'b0, 1'b1);
    run_op("hold2", {6'h00, 5'd1, 5'd6, 16'h0008}, 32'h0000_0700, 32'h0, 0, 32'h0, 1'b1,
           32'h0000_0708, 2, 0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;

    // Reset asserted while the request is outstanding.
    @(negedge clk);
    start = 1'b1; instruction = {6'h23, 5'd1, 5'd3, 16'h0010}; Read_data1 = 32'h40; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rstmid:in_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid:mem_req",  32'(mem_req), 32'd0);
    chk("rstmid:busy",     32'(busy),    32'd0);
    chk("rstmid:done",     32'(done),    32'd0);
    chk("rstmid:mem_addr", mem_addr,     32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("after_rst", {6'h23, 5'd1, 5'd3, 16'h0010}, 32'h0000_0040, 32'h0, 0, 32'h9999_0000, 1'b0,
           32'h0000_0050, 3, 1, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      instr = $urandom;
      r = $urandom_range(0, 9);
      if (r < 4)      instr[31:26] = 6'h23;
      else if (r < 8) instr[31:26] = 6'h2B;
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        rs[1:0]    = 2'b00;
        instr[1:0] = 2'b00;
      end
      rt    = $urandom;
      rdata = $urandom;
      r     = $urandom_range(0, 19);
      delay = (r > 17) ? -1 : r;
      model(instr, rs, delay, eaddr, lat, reqs, flt, rfwe);
      run_op($sformatf("rand%0d", n), instr, rs, rt, delay, rdata, 1'b0, eaddr, lat, reqs, flt, rfwe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
